pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the pipelined MIPS core.
//  Carries a control field and a data field under a valid/ready handshake.
//  An optional 2-entry skid buffer lets upstream ready be fully registered.
//  Provides a synchronous flush that squashes to a NOP bubble, and a saturating stall-cycle counter for profiling.
// PARAMETERS
//  CTRL_W  28  control-signal bits (ALU_OP, Memwrite, Regwrite, branch/jump flags, ...); zeroed on bubble
//  DATA_W  165 data bits (instr, PC+4, RD1, RD2, imm32, write-reg); held, not zeroed, on bubble
//  SKID    1   1 = 2-entry skid buffer, registered in_ready; 0 = single register, combinational in_ready
//  CNT_W   16  stall counter width
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  clr        in   1       synchronous flush (branch/jump squash)
//  in_valid   in   1       upstream has a stage word
//  in_ready   out  1       stage accepts this cycle
//  in_ctrl    in   CTRL_W  upstream control
//  in_data    in   DATA_W  upstream data
//  out_valid  out  1       stage word present (replaces the old Enable_out)
//  out_ready  in   1       downstream accepts; 0 = stall
//  out_ctrl   out  CTRL_W  control; forced to all-zero (NOP) whenever out_valid=0
//  out_data   out  DATA_W  data; value undefined (held) when out_valid=0
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): occupancy EMPTY; out_valid=0; out_ctrl=0; out_data=0; skid cleared; stall_cnt=0.
//    With SKID=1, in_ready=1 from the first edge after release.
//  - Accept = in_valid & in_ready. Emit = out_valid & out_ready. Strict FIFO order; no word dropped or duplicated.
//  - SKID=1, occupancy FSM:
//      EMPTY: accept -> ONE.
//      ONE:   accept & !emit -> TWO (word goes to skid); emit & !accept -> EMPTY; both -> ONE (main reloaded).
//      TWO:   in_ready=0; emit -> ONE (skid moves to main).
//    in_ready = (state!=TWO), driven straight from a flop, with no combinational path from out_ready.
//  - SKID=0: in_ready = !out_valid | out_ready (combinational). Two states only: EMPTY and ONE.
//  - Latency: 1 cycle from accept to out_valid when the stage is empty. Sustained throughput: 1 word/cycle while out_ready=1.
//  - clr: takes priority over accept and emit. Next state is EMPTY, out_valid=0, out_ctrl=0, skid invalidated.
//    While clr=1, in_ready=0, so no upstream word is consumed. Both main and skid words are squashed.
//  - clr together with out_ready=1 in the same cycle: the emit still counts downstream (the word was sampled);
//    the stage is empty afterwards.
//  - stall_cnt: increments when out_valid & !out_ready & !clr. Holds at 2^CNT_W-1. Cleared only by rst_n.
//  - Reset asserted mid-transfer: all state is dropped immediately; no partial word appears at out_*.
// STRUCTURE
//  - pipe_pkg.vh holds shared constants used by every stage instance:
//      occupancy encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
//      CTRL_NOP = all-zero;
//      per-stage default CTRL_W/DATA_W.
//  - Sub-module pipe_slot: one valid+ctrl+data register with load/clear. Instanced twice (main, skid);
//    the skid instance is generated only when SKID=1.
//  - The FSM and stall counter live in the top module.
// TESTING
//  1. Reset: rst_n=0 mid-run, with the stage at occupancy TWO
//     -> out_valid=0, out_ctrl=0, stall_cnt=0 asynchronously; in_ready=1 one edge after release.
//  2. Streaming: SKID=1, in_valid=1, out_ready=1, words 0x1..0x8
//     -> out_data shows 0x1..0x8 on consecutive cycles after 1-cycle latency; in_ready never drops.
//  3. Backpressure: out_ready=0 for 3 cycles while sending 0xA, 0xB, 0xC
//     -> 0xA held, 0xB in skid, in_ready=0, 0xC held upstream; stall_cnt=3.
//     Release -> 0xA, 0xB, 0xC in order.
//  4. Flush: at occupancy TWO assert clr for 1 cycle with in_valid=1
//     -> next cycle out_valid=0, out_ctrl=0, the upstream word is not consumed (in_ready=0 during clr).
//  5. SKID=0: out_ready toggling 1/0 every cycle
//     -> in_ready equals !out_valid|out_ready combinationally; no loss or duplication over 100 random words.
//  6. Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants for the pipe_stage_hs pipeline-register family.
package pipe_stage_hs_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t ST_EMPTY = 2'd0;
  localparam occ_t ST_ONE   = 2'd1;
  localparam occ_t ST_TWO   = 2'd2;

  // Bubble control value is all-zero at any width.
  localparam logic CTRL_NOP_BIT = 1'b0;

  localparam int CTRL_W_DEF = 28;
  localparam int DATA_W_DEF = 165;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One valid+ctrl+data register; ctrl is zeroed whenever the slot goes empty.
module pipe_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Data is deliberately held on clear/drop; only ctrl must become a NOP.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = {CTRL_W{CTRL_NOP_BIT}};
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end else if (drop) begin
      valid_d = 1'b0;
      ctrl_d  = {CTRL_W{CTRL_NOP_BIT}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid, flush and stall counter.
// state    | meaning
// ST_EMPTY | no word held
// ST_ONE   | word in main slot only
// ST_TWO   | main and skid both full, upstream blocked
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int          CTRL_W = CTRL_W_DEF,
  parameter int          DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1,
  parameter int          CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_t              state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, emit;
  logic              main_load, main_drop;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] skid_data, main_ld_data;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_drop = 1'b0;
    if (clr) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept && SKID != 0) begin
            state_d = ST_TWO;
          end else if (emit && !accept) begin
            main_drop = 1'b1;
            state_d   = ST_EMPTY;
          end
        end
        ST_TWO: if (emit) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // In ST_TWO the main slot refills from the skid, otherwise from upstream.
  assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
  assign main_ld_data = skid_valid ? skid_data : in_data;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !clr && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (main_load),
    .drop    (main_drop),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (out_valid),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q, in_ready_d;
    logic skid_load, skid_drop;

    assign skid_load  = (state_q == ST_ONE) & accept & ~emit & ~clr;
    assign skid_drop  = (state_q == ST_TWO) & emit & ~clr;
    assign in_ready_d = (state_d != ST_TWO);

    // Registered ready keeps out_ready off the upstream timing path.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_ready_q <= 1'b0;
      else        in_ready_q <= in_ready_d;
    end

    assign in_ready = in_ready_q & ~clr;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (skid_load),
      .drop    (skid_drop),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
    );
  end else begin : g_noskid
    assign in_ready   = (~out_valid | out_ready) & ~clr;
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue models for SKID=1 and SKID=0 instances plus directed literal checks.
module tb_pipe_stage_hs;

  localparam int CW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mkc(input logic [DW-1:0] d);
    return {d[6:0], 1'b1};
  endfunction

  // ---------------- DUT A: SKID=1, CNT_W=16 ----------------
  logic a_clr = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [15:0] a_stall;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));

  // ---------------- DUT B: SKID=0 ----------------
  logic b_clr = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [DW-1:0] b_in_data = '0, b_out_data;
  logic [15:0] b_stall;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall));

  // ---------------- DUT C: SKID=1, CNT_W=4 ----------------
  logic c_clr = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [CW-1:0] c_in_ctrl = '0, c_out_ctrl;
  logic [DW-1:0] c_in_data = '0, c_out_data;
  logic [3:0] c_stall;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .stall_cnt(c_stall));

  // ---------------- Models: FIFO of held words ----------------
  word_t qa[$];
  word_t qb[$];
  bit    ma_rdy;
  int    ma_cnt, mb_cnt;

  always @(posedge clk or negedge rst_n) begin
    bit acc, emit;
    if (!rst_n) begin
      qa.delete();
      ma_rdy = 0;
      ma_cnt = 0;
    end else begin
      acc  = a_in_valid && ma_rdy && !a_clr;
      emit = (qa.size() > 0) && a_out_ready;
      if (qa.size() > 0 && !a_out_ready && !a_clr && ma_cnt < 65535) ma_cnt++;
      if (a_clr) qa.delete();
      else begin
        if (emit) void'(qa.pop_front());
        if (acc) qa.push_back('{c: a_in_ctrl, d: a_in_data});
      end
      ma_rdy = (qa.size() < 2);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    bit acc, emit;
    if (!rst_n) begin
      qb.delete();
      mb_cnt = 0;
    end else begin
      acc  = b_in_valid && (qb.size() == 0 || b_out_ready) && !b_clr;
      emit = (qb.size() > 0) && b_out_ready;
      if (qb.size() > 0 && !b_out_ready && !b_clr && mb_cnt < 65535) mb_cnt++;
      if (b_clr) qb.delete();
      else begin
        if (emit) void'(qb.pop_front());
        if (acc) qb.push_back('{c: b_in_ctrl, d: b_in_data});
      end
    end
  end

  // Compare process plus emitted-word logs.
  logic [DW-1:0] a_log[$];
  logic [DW-1:0] b_log[$];

  always @(negedge clk) begin
    chk("a_out_valid", a_out_valid, qa.size() > 0);
    chk("a_out_ctrl", a_out_ctrl, (qa.size() > 0) ? qa[0].c : '0);
    if (qa.size() > 0) chk("a_out_data", a_out_data, qa[0].d);
    chk("a_in_ready", a_in_ready, ma_rdy && !a_clr);
    chk("a_stall_cnt", a_stall, ma_cnt);
    chk("b_out_valid", b_out_valid, qb.size() > 0);
    chk("b_out_ctrl", b_out_ctrl, (qb.size() > 0) ? qb[0].c : '0);
    if (qb.size() > 0) chk("b_out_data", b_out_data, qb[0].d);
    chk("b_in_ready", b_in_ready, (qb.size() == 0 || b_out_ready) && !b_clr);
    chk("b_stall_cnt", b_stall, mb_cnt);
    if (rst_n && a_out_valid && a_out_ready) a_log.push_back(a_out_data);
    if (rst_n && b_out_valid && b_out_ready) b_log.push_back(b_out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [DW-1:0] d);
    a_in_valid = v;
    a_in_data  = d;
    a_in_ctrl  = mkc(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] b_words[100];

  initial begin
    // Power-on reset
    #12 rst_n = 1'b1;
    step();
    chk("por_in_ready", a_in_ready, 1);
    chk("por_stall", a_stall, 0);

    // Streaming 1..8 with out_ready=1
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_drive(1, DW'(i));
      @(negedge clk);
      chk("stream_rdy", a_in_ready, 1);
      if (i == 1) chk("stream_lat", a_out_valid, 0);
      else        chk("stream_data", a_out_data, DW'(i - 1));
      step();
    end
    a_drive(0, '0);
    @(negedge clk);
    chk("stream_last", a_out_data, 8);
    step();
    step();

    // Backpressure A, B, C
    a_log.delete();
    a_out_ready = 0;
    a_drive(1, 32'hA);
    step();
    a_drive(1, 32'hB);
    step();
    a_drive(1, 32'hC);
    step();
    @(negedge clk);
    chk("bp_main_held", a_out_data, 32'hA);
    chk("bp_in_ready", a_in_ready, 0);
    step();
    a_out_ready = 1;
    @(negedge clk);
    chk("bp_stall3", a_stall, 3);
    chk("bp_still_a", a_out_data, 32'hA);
    step();
    step();
    a_drive(0, '0);
    repeat (3) step();
    chk("bp_count", a_log.size(), 3);
    if (a_log.size() == 3) begin
      chk("bp_order0", a_log[0], 32'hA);
      chk("bp_order1", a_log[1], 32'hB);
      chk("bp_order2", a_log[2], 32'hC);
    end

    // Flush at occupancy TWO
    a_out_ready = 0;
    a_drive(1, 32'hD);
    step();
    a_drive(1, 32'hE);
    step();
    a_drive(1, 32'hF);
    a_clr = 1;
    @(negedge clk);
    chk("flush_rdy", a_in_ready, 0);
    step();
    a_clr = 0;
    a_drive(0, '0);
    @(negedge clk);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_ctrl", a_out_ctrl, 0);
    step();
    @(negedge clk);
    chk("flush_no_consume", a_out_valid, 0);
    step();

    // Mid-run asynchronous reset at occupancy TWO
    a_drive(1, 32'h61);
    step();
    a_drive(1, 32'h62);
    step();
    a_drive(0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ctrl", a_out_ctrl, 0);
    chk("rst_data", a_out_data, 0);
    chk("rst_stall", a_stall, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_empty", a_out_valid, 0);
    a_out_ready = 1;

    // SKID=0, out_ready toggling, 100 random words
    for (int i = 0; i < 100; i++) b_words[i] = $urandom;
    begin
      int idx = 0;
      int cyc = 0;
      bit acc;
      b_log.delete();
      b_out_ready = 1;
      b_in_valid  = 1;
      b_in_data   = b_words[0];
      b_in_ctrl   = mkc(b_words[0]);
      while (b_log.size() < 100 && cyc < 1000) begin
        @(negedge clk);
        chk("b_rdy_comb", b_in_ready, (!b_out_valid) | b_out_ready);
        acc = b_in_valid && b_in_ready;
        step();
        cyc++;
        if (acc) idx++;
        if (idx < 100) begin
          b_in_data = b_words[idx];
          b_in_ctrl = mkc(b_words[idx]);
        end else begin
          b_in_valid = 0;
        end
        b_out_ready = !b_out_ready;
      end
      b_in_valid = 0;
      chk("b_count", b_log.size(), 100);
      for (int i = 0; i < 100 && i < b_log.size(); i++) chk("b_order", b_log[i], b_words[i]);
    end
    b_out_ready = 1;
    step();

    // Saturation with CNT_W=4
    c_in_valid = 1;
    c_in_data  = 32'h77;
    c_in_ctrl  = mkc(32'h77);
    step();
    c_in_valid = 0;
    repeat (14) @(posedge clk);
    #1;
    chk("sat_14", c_stall, 14);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", c_stall, 15);
    chk("sat_valid", c_out_valid, 1);
    chk("sat_data", c_out_data, 32'h77);
    chk("sat_in_ready", c_in_ready, 1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
